// File: rtl/rr_src_scheduler_pkg.sv
// Shared definitions for the round-robin source scheduler: state encoding,
// parameter defaults and the width of the fetch timeout counter.
package rr_src_scheduler_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_SRC    = 4;
    localparam int DEF_ID_WIDTH   = 2;
    localparam int DEF_TIMEOUT    = 8;
    localparam int TMO_WIDTH      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        SEND  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/rr_src_scheduler_rr_pick.sv
// Combinational round-robin picker: first set mask bit searching from ptr+1
// upward modulo num_src, with ptr itself considered last.
module rr_pick
    import rr_src_scheduler_pkg::*;
#(
    parameter int num_src  = DEF_NUM_SRC,
    parameter int id_width = DEF_ID_WIDTH
) (
    input  logic [num_src-1:0]  mask,
    input  logic [id_width-1:0] ptr,
    output logic                valid,
    output logic [id_width-1:0] index
);

    // Walk offsets from largest to smallest so the nearest hit after ptr is kept.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int k = num_src; k >= 1; k--) begin
            for (int g = 0; g < num_src; g++) begin
                if (mask[g] && (g == ((int'(ptr) + k) % num_src))) begin
                    valid = 1'b1;
                    index = id_width'(g);
                end else begin
                    valid = valid;
                end
            end
        end
    end

endmodule

// File: rtl/rr_src_scheduler.sv
// Round-robin scheduler: fetches one word at a time from enabled sources and
// hands it to a single downstream operator, with per-source grant counters.
module rr_src_scheduler
    import rr_src_scheduler_pkg::*;
#(
    parameter int data_width = DEF_DATA_WIDTH,
    parameter int num_src    = DEF_NUM_SRC,
    parameter int id_width   = DEF_ID_WIDTH,
    parameter int timeout    = DEF_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [num_src-1:0]             src_en,
    output logic [num_src-1:0]             src_req,
    input  logic [num_src-1:0]             src_ack,
    input  logic [data_width*num_src-1:0]  src_din,
    input  logic                           dst_req,
    output logic                           dst_ack,
    output logic [data_width-1:0]          dst_dout,
    output logic [id_width-1:0]            dst_id,
    output logic [32*num_src-1:0]          grant_count,
    output logic [31:0]                    skip_count
);

    sched_state_e          state_r;
    logic [id_width-1:0]   cur_r;
    logic [id_width-1:0]   ptr_r;
    logic [TMO_WIDTH-1:0]  tmo_r;
    logic [data_width-1:0] word_r;
    logic [31:0]           grant_r [num_src];

    logic                  pick_valid_s;
    logic [id_width-1:0]   pick_idx_s;
    logic [num_src-1:0]    cur_onehot_s;
    logic                  cur_ack_s;
    logic                  cur_en_s;
    logic                  tmo_done_s;
    logic [data_width-1:0] cur_word_s;

    function automatic logic [num_src-1:0] onehot(input logic [id_width-1:0] idx);
        return {{(num_src-1){1'b0}}, 1'b1} << idx;
    endfunction

    rr_pick #(
        .num_src  (num_src),
        .id_width (id_width)
    ) u_pick (
        .mask  (src_en),
        .ptr   (ptr_r),
        .valid (pick_valid_s),
        .index (pick_idx_s)
    );

    assign cur_onehot_s = onehot(cur_r);
    assign cur_ack_s    = |(src_ack & cur_onehot_s);
    assign cur_en_s     = |(src_en & cur_onehot_s);
    assign tmo_done_s   = (tmo_r == TMO_WIDTH'(timeout - 1));

    // Select the data slice of the source currently being fetched.
    always_comb begin
        cur_word_s = '0;
        for (int g = 0; g < num_src; g++) begin
            if (cur_r == id_width'(g)) begin
                cur_word_s = src_din[data_width*g +: data_width];
            end else begin
                cur_word_s = cur_word_s;
            end
        end
    end

    for (genvar g = 0; g < num_src; g++) begin : g_grant
        assign grant_count[32*g +: 32] = grant_r[g];
    end

    // Scheduler FSM with all outputs and counters registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            cur_r      <= '0;
            ptr_r      <= id_width'(num_src - 1);
            tmo_r      <= '0;
            word_r     <= '0;
            src_req    <= '0;
            dst_ack    <= 1'b0;
            dst_dout   <= '0;
            dst_id     <= '0;
            skip_count <= 32'd0;
            for (int g = 0; g < num_src; g++) begin
                grant_r[g] <= 32'd0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    dst_ack <= 1'b0;
                    if (pick_valid_s) begin
                        cur_r   <= pick_idx_s;
                        src_req <= onehot(pick_idx_s);
                        tmo_r   <= '0;
                        state_r <= FETCH;
                    end else begin
                        src_req <= '0;
                    end
                end
                FETCH: begin
                    // A data pulse beats both a disable and timeout expiry.
                    if (cur_ack_s) begin
                        word_r  <= cur_word_s;
                        src_req <= '0;
                        state_r <= HOLD;
                    end else if (!cur_en_s) begin
                        src_req <= '0;
                        ptr_r   <= cur_r;
                        state_r <= IDLE;
                    end else if (tmo_done_s) begin
                        src_req    <= '0;
                        skip_count <= skip_count + 32'd1;
                        ptr_r      <= cur_r;
                        state_r    <= IDLE;
                    end else begin
                        tmo_r <= tmo_r + {{(TMO_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                HOLD: begin
                    if (dst_req) begin
                        dst_ack  <= 1'b1;
                        dst_dout <= word_r;
                        dst_id   <= cur_r;
                        state_r  <= SEND;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                SEND: begin
                    dst_ack        <= 1'b0;
                    grant_r[cur_r] <= grant_r[cur_r] + 32'd1;
                    ptr_r          <= cur_r;
                    state_r        <= IDLE;
                end
                default: begin
                    src_req <= '0;
                    dst_ack <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_src_scheduler.sv
// Directed self-checking bench for rr_src_scheduler with default parameters.
module tb_rr_src_scheduler;

    localparam int DW = 32;
    localparam int NS = 4;
    localparam int IW = 2;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NS-1:0]     src_en = '0;
    logic [NS-1:0]     src_req;
    logic [NS-1:0]     src_ack = '0;
    logic [DW*NS-1:0]  src_din = '0;
    logic              dst_req = 1'b0;
    logic              dst_ack;
    logic [DW-1:0]     dst_dout;
    logic [IW-1:0]     dst_id;
    logic [32*NS-1:0]  grant_count;
    logic [31:0]       skip_count;

    logic [NS-1:0]     auto_mask = '0;
    int                n_checks = 0;
    int                n_fail = 0;

    always #5 clk = ~clk;

    rr_src_scheduler #(
        .data_width (DW),
        .num_src    (NS),
        .id_width   (IW),
        .timeout    (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_en      (src_en),
        .src_req     (src_req),
        .src_ack     (src_ack),
        .src_din     (src_din),
        .dst_req     (dst_req),
        .dst_ack     (dst_ack),
        .dst_dout    (dst_dout),
        .dst_id      (dst_id),
        .grant_count (grant_count),
        .skip_count  (skip_count)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int g);
        return 32'hC0DE_0100 + 32'(g);
    endfunction

    function automatic logic [31:0] grant_of(input int g);
        return grant_count[32*g +: 32];
    endfunction

    task automatic set_word(input int g, input logic [31:0] w);
        src_din[32*g +: 32] = w;
    endtask

    // Sources that are in auto_mask answer a request in the same cycle they see it.
    task automatic step();
        @(posedge clk);
        #1;
        src_ack = src_req & auto_mask;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        src_ack = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        int last;
        int gchk;
        int stray;
        int n1;
        int found;
        logic [NS-1:0] first_after;
        logic [DW-1:0] got_dout;
        logic [IW-1:0] got_id;

        for (int g = 0; g < NS; g++) set_word(g, word_of(g));

        // Reset values while rst is held low.
        rst = 1'b0;
        step();
        step();
        check_val("rst_src_req", src_req, 0);
        check_val("rst_dst_ack", dst_ack, 0);
        check_val("rst_dst_dout", dst_dout, 0);
        check_val("rst_dst_id", dst_id, 0);
        check_val("rst_skip", skip_count, 0);
        for (int g = 0; g < NS; g++) check_val("rst_grant", grant_of(g), 0);

        // All enabled, immediate acks, downstream always ready.
        src_en = 4'hF;
        auto_mask = 4'hF;
        dst_req = 1'b1;
        rst = 1'b1;
        acks = 0;
        last = 0;
        gchk = 0;
        for (int c = 1; c <= 60 && acks < 5; c++) begin
            step();
            if (acks == 4 && gchk == 0) begin
                for (int g = 0; g < NS; g++) check_val("rr_grant1", grant_of(g), 1);
                gchk = 1;
            end
            if (dst_ack) begin
                check_val("rr_id", dst_id, acks % NS);
                check_val("rr_dout", dst_dout, word_of(acks % NS));
                if (acks > 0) check_val("rr_gap", c - last, 4);
                last = c;
                acks++;
            end
        end
        check_val("rr_acks", acks, 5);
        check_val("rr_gchk", gchk, 1);

        // Only source 2 enabled.
        src_en = 4'b0100;
        apply_reset();
        acks = 0;
        stray = 0;
        for (int c = 1; c <= 24; c++) begin
            step();
            if (c == 20) src_en = 4'b0000;
            if ((src_req & 4'b1011) != 4'b0000) stray++;
            if (dst_ack) acks++;
        end
        check_val("one_stray", stray, 0);
        check_val("one_acks", acks, 5);
        check_val("one_grant2", grant_of(2), 5);
        check_val("one_grant0", grant_of(0), 0);
        check_val("one_grant1", grant_of(1), 0);
        check_val("one_grant3", grant_of(3), 0);

        // Source 1 never answers: timeout skip.
        src_en = 4'hF;
        auto_mask = 4'b1101;
        apply_reset();
        n1 = 0;
        found = 0;
        first_after = '0;
        for (int c = 0; c < 60 && found == 0; c++) begin
            step();
            if (src_req[1]) n1++;
            else if (n1 > 0 && src_req != 4'b0000) begin
                first_after = src_req;
                found = 1;
            end
        end
        check_val("tmo_found", found, 1);
        check_val("tmo_req1_cycles", n1, TO);
        check_val("tmo_next_req", first_after, 4'b0100);
        check_val("tmo_skip", skip_count, 1);
        check_val("tmo_grant1", grant_of(1), 0);

        // Ack on the last FETCH cycle wins; acks from other sources are ignored.
        src_en = 4'b0010;
        auto_mask = 4'b0000;
        apply_reset();
        n1 = 0;
        found = 0;
        got_dout = '0;
        got_id = '0;
        for (int c = 0; c < 60 && found == 0; c++) begin
            step();
            if (src_req[1]) begin
                n1++;
                src_ack = (n1 == TO) ? 4'b0010 : 4'b1101;
            end
            if (dst_ack) begin
                found = 1;
                got_dout = dst_dout;
                got_id = dst_id;
            end
        end
        check_val("late_found", found, 1);
        check_val("late_req1_cycles", n1, TO);
        check_val("late_dout", got_dout, word_of(1));
        check_val("late_id", got_id, 1);
        check_val("late_skip", skip_count, 0);

        // Long HOLD with downstream not ready.
        src_en = 4'b1000;
        auto_mask = 4'hF;
        dst_req = 1'b0;
        set_word(3, 32'h0000_00AB);
        apply_reset();
        repeat (3) step();
        src_en = 4'b0000;
        set_word(3, 32'hDEAD_BEEF);
        acks = 0;
        stray = 0;
        repeat (20) begin
            step();
            if (dst_ack) acks++;
            if (src_req != 4'b0000) stray++;
        end
        check_val("hold_no_ack", acks, 0);
        check_val("hold_no_req", stray, 0);
        dst_req = 1'b1;
        step();
        check_val("hold_send_ack", dst_ack, 1);
        check_val("hold_send_dout", dst_dout, 32'h0000_00AB);
        check_val("hold_send_id", dst_id, 3);
        step();
        check_val("hold_ack_drop", dst_ack, 0);
        check_val("hold_grant3", grant_of(3), 1);
        repeat (3) step();
        check_val("hold_keep_dout", dst_dout, 32'h0000_00AB);
        check_val("hold_keep_id", dst_id, 3);

        // Asynchronous reset while a word is held.
        src_en = 4'hF;
        dst_req = 1'b0;
        repeat (3) step();
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_src_req", src_req, 0);
        check_val("arst_dst_ack", dst_ack, 0);
        check_val("arst_dout", dst_dout, 0);
        check_val("arst_id", dst_id, 0);
        check_val("arst_grant3", grant_of(3), 0);
        step();
        rst = 1'b1;
        dst_req = 1'b1;
        found = 0;
        first_after = '0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            step();
            if (src_req != 4'b0000) begin
                first_after = src_req;
                found = 1;
            end
        end
        check_val("arst_found", found, 1);
        check_val("arst_first_req", first_after, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
